// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared constants, state type and alignment helpers for the
//               memory-access stage.
// Revision    : 1.0  initial release
// ============================================================================
package lsu_pkg;

    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } lsu_state_t;

    // funct3[1:0] selects the access width; unused encoding 2'b11 is treated as a word.
    function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        case (f3[1:0])
            2'b00:   ok = 1'b1;
            2'b01:   ok = ~off[0];
            default: ok = (off == 2'b00);
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_fmt.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_fmt
// Description : Selects the addressed byte/half/word of a load data word and
//               sign- or zero-extends it according to funct3.
// Revision    : 1.0  initial release
// ============================================================================
module lsu_load_fmt
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_f3,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_signed;

    always_comb begin
        w_byte   = 8'h00;
        w_half   = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
        w_signed = ~i_f3[2];
        case (i_off)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
    end

    always_comb begin
        o_result = i_rdata;
        case (i_f3[1:0])
            2'b00:   o_result = {{24{w_signed & w_byte[7]}}, w_byte};
            2'b01:   o_result = {{16{w_signed & w_half[15]}}, w_half};
            default: o_result = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_lsu
// Description : RV32 memory-access stage: issues data-memory requests, stalls
//               the pipe while an access is outstanding, registers MEM/WB.
// Revision    : 1.0  initial release
// ============================================================================
module mem_stage_lsu
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m_valid,
    input  logic [4:0]  m_op,
    input  logic [2:0]  m_f3,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    input  logic [31:0] m_result,
    input  logic [4:0]  m_rd,
    input  logic        m_use_rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        stall_req,
    output logic        misalign,
    output logic        w_valid,
    output logic        w_we,
    output logic [4:0]  w_rd,
    output logic [31:0] w_data
);

    lsu_state_t  r_state;
    lsu_state_t  w_next_state;
    logic [2:0]  r_f3;
    logic [1:0]  r_off;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_memop;
    logic        w_aligned;
    logic        w_access;
    logic        w_complete;
    logic        w_retire;
    logic        w_bad_align;
    logic [31:0] w_load_val;

    assign w_is_load  = (m_op == OP_LOAD);
    assign w_is_store = (m_op == OP_STORE);
    assign w_memop    = w_is_load | w_is_store;
    assign w_aligned  = is_aligned(m_f3, m_addr[1:0]);
    assign w_access   = m_valid & w_memop & w_aligned;

    // Request fields come straight from the held EX/MEM inputs, so they stay stable in REQ.
    assign dmem_we    = w_is_store;
    assign dmem_addr  = {m_addr[31:2], 2'b00};

    always_comb begin
        dmem_wstrb = 4'h0;
        dmem_wdata = m_wdata;
        if (w_is_store) begin
            case (m_f3[1:0])
                2'b00: begin
                    dmem_wstrb = 4'b0001 << m_addr[1:0];
                    dmem_wdata = {4{m_wdata[7:0]}};
                end
                2'b01: begin
                    dmem_wstrb = 4'b0011 << m_addr[1:0];
                    dmem_wdata = {2{m_wdata[15:0]}};
                end
                default: begin
                    dmem_wstrb = 4'hF;
                    dmem_wdata = m_wdata;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    if (!dmem_gnt) begin
                        w_next_state = S_REQ;
                    end else if (w_is_load) begin
                        w_next_state = S_WAIT;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            S_REQ: begin
                if (dmem_gnt) begin
                    w_next_state = w_is_load ? S_WAIT : S_IDLE;
                end
            end
            S_WAIT: begin
                if (dmem_rvalid) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        dmem_req   = 1'b0;
        w_complete = 1'b0;
        misalign   = 1'b0;
        case (r_state)
            S_IDLE: begin
                dmem_req   = w_access;
                w_complete = w_access & dmem_gnt & w_is_store;
                misalign   = m_valid & w_memop & ~w_aligned;
            end
            S_REQ: begin
                dmem_req   = 1'b1;
                w_complete = dmem_gnt & w_is_store;
            end
            S_WAIT: begin
                w_complete = dmem_rvalid;
            end
            default: begin
                dmem_req   = 1'b0;
                w_complete = 1'b0;
            end
        endcase
    end

    assign stall_req   = w_access & ~w_complete;
    assign w_retire    = m_valid & ~stall_req;
    assign w_bad_align = w_memop & ~w_aligned;

    // Width and lane of a load are frozen at issue and applied when data returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f3  <= 3'b000;
            r_off <= 2'b00;
        end else if ((r_state == S_IDLE) && w_access) begin
            r_f3  <= m_f3;
            r_off <= m_addr[1:0];
        end
    end

    lsu_load_fmt u_load_fmt (
        .i_rdata  (dmem_rdata),
        .i_off    (r_off),
        .i_f3     (r_f3),
        .o_result (w_load_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_valid <= 1'b0;
            w_we    <= 1'b0;
            w_rd    <= 5'd0;
            w_data  <= 32'd0;
        end else if (w_retire) begin
            w_valid <= 1'b1;
            w_we    <= m_use_rd & (m_rd != 5'd0) & ~w_bad_align & ~w_is_store;
            w_rd    <= m_rd;
            w_data  <= (w_is_load & w_aligned) ? w_load_val : m_result;
        end else begin
            w_valid <= 1'b0;
            w_we    <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_lsu
// Description : Randomized self-checking bench for mem_stage_lsu against a
//               behavioural model of the access/formatting rules.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m_valid;
    logic [4:0]  m_op;
    logic [2:0]  m_f3;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_result;
    logic [4:0]  m_rd;
    logic        m_use_rd;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        stall_req;
    logic        misalign;
    logic        w_valid;
    logic        w_we;
    logic [4:0]  w_rd;
    logic [31:0] w_data;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] x_addr;
    logic        x_we;
    logic [3:0]  x_strb;
    logic [31:0] x_wdata;

    always #5 clk = ~clk;

    mem_stage_lsu dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m_valid     (m_valid),
        .m_op        (m_op),
        .m_f3        (m_f3),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_result    (m_result),
        .m_rd        (m_rd),
        .m_use_rd    (m_use_rd),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wstrb  (dmem_wstrb),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .stall_req   (stall_req),
        .misalign    (misalign),
        .w_valid     (w_valid),
        .w_we        (w_we),
        .w_rd        (w_rd),
        .w_data      (w_data)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Inputs already driven (just after negedge). Checks combinational outputs,
    // crosses the rising edge, checks the W slot, returns at the next negedge.
    task automatic step(input logic e_req, input logic e_stall, input logic e_mis,
                        input logic e_ret, input logic e_we, input logic [4:0] e_rd,
                        input logic [31:0] e_data);
        #1;
        check("dmem_req", {31'd0, dmem_req}, {31'd0, e_req});
        check("stall_req", {31'd0, stall_req}, {31'd0, e_stall});
        check("misalign", {31'd0, misalign}, {31'd0, e_mis});
        if (e_req) begin
            check("dmem_addr", dmem_addr, x_addr);
            check("dmem_we", {31'd0, dmem_we}, {31'd0, x_we});
            if (x_we) begin
                check("dmem_wstrb", {28'd0, dmem_wstrb}, {28'd0, x_strb});
                check("dmem_wdata", dmem_wdata, x_wdata);
            end
        end
        @(posedge clk);
        #1;
        check("w_valid", {31'd0, w_valid}, {31'd0, e_ret});
        check("w_we", {31'd0, w_we}, {31'd0, e_ret & e_we});
        if (e_ret) begin
            check("w_rd", {27'd0, w_rd}, {27'd0, e_rd});
            check("w_data", w_data, e_data);
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] word);
        longint v;
        v = (longint'(word) >> (8 * off));
        case (f3)
            3'b000:  begin v = v % 256;   if (v >= 128)   v = v - 256;   end
            3'b100:  v = v % 256;
            3'b001:  begin v = v % 65536; if (v >= 32768) v = v - 65536; end
            3'b101:  v = v % 65536;
            default: v = longint'(word);
        endcase
        return v[31:0];
    endfunction

    task automatic run_instr(input logic v, input logic [4:0] op, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] res, input logic [4:0] rd, input logic urd,
                             input int gd, input int lat, input logic [31:0] rdata);
        logic        ld, st, mem, al, mis, e_we;
        int          width;
        logic [31:0] e_data;
        ld    = (op == 5'b00000);
        st    = (op == 5'b01000);
        mem   = ld | st;
        width = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        al    = (addr % width) == 0;
        mis   = v & mem & ~al;
        e_we  = urd & (rd != 0) & ~mis & ~st;
        e_data = (ld & al) ? model_load(f3, addr[1:0], rdata) : res;

        x_addr  = addr & 32'hFFFF_FFFC;
        x_we    = st;
        x_strb  = (width == 4) ? 4'hF : 4'((width == 1 ? 1 : 3) << (addr % 4));
        x_wdata = (width == 1) ? {4{wd[7:0]}} : (width == 2) ? {2{wd[15:0]}} : wd;

        m_valid = v; m_op = op; m_f3 = f3; m_addr = addr; m_wdata = wd;
        m_result = res; m_rd = rd; m_use_rd = urd;

        if (!v || !mem || !al) begin
            dmem_gnt    = 1'($urandom_range(0, 1));
            dmem_rvalid = 1'($urandom_range(0, 1));
            dmem_rdata  = $urandom;
            step(1'b0, 1'b0, mis, v, e_we, rd, e_data);
        end else begin
            for (int c = 0; c <= gd; c++) begin
                dmem_gnt    = (c == gd);
                dmem_rvalid = 1'($urandom_range(0, 1));
                dmem_rdata  = $urandom;
                step(1'b1, ~(st && c == gd), 1'b0, st && c == gd, e_we, rd, e_data);
            end
            if (ld) begin
                for (int c = 1; c <= lat; c++) begin
                    dmem_gnt    = 1'($urandom_range(0, 1));
                    dmem_rvalid = (c == lat);
                    dmem_rdata  = (c == lat) ? rdata : $urandom;
                    step(1'b0, c != lat, 1'b0, c == lat, e_we, rd, e_data);
                end
            end
        end
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    endtask

    initial begin
        logic [4:0] alu_ops [4];
        logic [2:0] ld_f3 [5];
        logic [2:0] st_f3 [3];
        int kind;
        alu_ops = '{5'b01100, 5'b00100, 5'b01101, 5'b11000};
        ld_f3   = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        st_f3   = '{3'b000, 3'b001, 3'b010};

        rst_n = 1'b0; m_valid = 1'b0; m_op = 5'b01100; m_f3 = 3'b000; m_addr = 32'd0;
        m_wdata = 32'd0; m_result = 32'd0; m_rd = 5'd0; m_use_rd = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_w_valid", {31'd0, w_valid}, 32'd0);
        check("rst_w_data", w_data, 32'd0);
        check("rst_w_rd", {27'd0, w_rd}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // SB to byte lane 3, granted immediately
        run_instr(1, 5'b01000, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0, 5'd0, 0, 0, 0, 32'h0);
        // LB, grant in cycle 0, data in cycle 3
        run_instr(1, 5'b00000, 3'b000, 32'h0000_2001, 32'h0, 32'h0, 5'd5, 1, 0, 3, 32'h0000_80FF);
        // LHU with grant held off two cycles
        run_instr(1, 5'b00000, 3'b101, 32'h0000_2002, 32'h0, 32'h0, 5'd9, 1, 2, 1, 32'hBEEF_1234);
        // Misaligned LW
        run_instr(1, 5'b00000, 3'b010, 32'h0000_3002, 32'h0, 32'h0, 5'd4, 1, 0, 1, 32'h0);
        // Back-to-back ALU ops, first targets x0
        run_instr(1, 5'b01100, 3'b000, 32'h0, 32'h0, 32'h0000_0055, 5'd0, 1, 0, 0, 32'h0);
        run_instr(1, 5'b01100, 3'b000, 32'h0, 32'h0, 32'h1234_5678, 5'd7, 1, 0, 0, 32'h0);

        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: run_instr(1, 5'b00000, ld_f3[$urandom_range(0, 4)], $urandom, $urandom,
                             $urandom, 5'($urandom), 1'($urandom), $urandom_range(0, 3),
                             $urandom_range(1, 3), $urandom);
                1: run_instr(1, 5'b01000, st_f3[$urandom_range(0, 2)], $urandom, $urandom,
                             $urandom, 5'($urandom), 1'($urandom), $urandom_range(0, 3),
                             1, $urandom);
                2: run_instr(1, alu_ops[$urandom_range(0, 3)], 3'($urandom), $urandom, $urandom,
                             $urandom, 5'($urandom), 1'($urandom), 0, 0, $urandom);
                default: run_instr(0, 5'b00000, 3'b010, 32'h0, $urandom, $urandom,
                                   5'($urandom), 1'($urandom), 0, 0, $urandom);
            endcase
        end

        // Reset while a load waits for data; the late rvalid must not retire anything.
        m_valid = 1; m_op = 5'b00000; m_f3 = 3'b010; m_addr = 32'h0000_4000;
        m_rd = 5'd3; m_use_rd = 1'b1; dmem_gnt = 1'b1;
        x_addr = 32'h0000_4000; x_we = 1'b0;
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        dmem_gnt = 1'b0;
        rst_n = 1'b0; m_valid = 1'b0;
        #1;
        check("arst_w_valid", {31'd0, w_valid}, 32'd0);
        check("arst_w_rd", {27'd0, w_rd}, 32'd0);
        check("arst_w_data", w_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        dmem_rvalid = 1'b0;
        run_instr(1, 5'b01000, 3'b001, 32'h0000_5002, 32'h0000_C3D4, 32'h0, 5'd0, 0, 1, 1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
